// File: rtl/dev_boot_ctrl.sv
// Boot sequencer: RESET -> LOAD -> RUN -> HALT/TIMEOUT, with restart, sub-system reset pulse,
// run-phase watchdog and activity-LED stretching. Optional macro BOOT_CTRL_RUN_COUNT_EN enables run_cycles.
module dev_boot_ctrl #(
    parameter int                BYTE_W         = 8,
    parameter int                RST_CYCLES     = 4,
    parameter int                TIMEOUT_CYCLES = 0,
    parameter int                STRETCH_CYCLES = 1_200_000,
    parameter logic [BYTE_W-1:0] TIMEOUT_CODE   = 8'hEE,
    parameter int                CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              loader_done,
    input  logic [BYTE_W-1:0] loader_byte_val,
    input  logic              loader_byte_valid,
    input  logic              cpu_halted,
    input  logic [BYTE_W-1:0] cpu_exit_code,
    output logic              sub_rst,
    output logic              select,
    output logic              cpu_en,
    output logic [BYTE_W-1:0] hex_val,
    output logic              led_activity,
    output logic              led_halted,
    output logic              led_timeout,
    output logic [CNT_W-1:0]  run_cycles
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SW    = (STRETCH_CYCLES > 0) ? $clog2(STRETCH_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_RESET,
        S_LOAD,
        S_RUN,
        S_HALT,
        S_TIMEOUT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [RST_W-1:0]    r_rst_cnt;
    logic [CNT_W-1:0]    r_wd_cnt;
    logic [SW-1:0]       r_stretch_cnt;
    logic [BYTE_W-1:0]   r_hex;
    logic                w_rst_done;
    logic                w_wd_hit;
    logic                w_run_start;

    assign w_rst_done  = (r_rst_cnt == RST_W'(RST_CYCLES - 1));
    assign w_wd_hit    = (TIMEOUT_CYCLES != 0) && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_run_start = (r_state == S_LOAD) && loader_done && !restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        sub_rst      = 1'b0;
        select       = 1'b0;
        cpu_en       = 1'b0;
        led_halted   = 1'b0;
        led_timeout  = 1'b0;
        case (r_state)
            S_RESET: begin
                sub_rst = 1'b1;
                if (w_rst_done) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (loader_done) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                select = 1'b1;
                cpu_en = 1'b1;
                // A halt seen on the watchdog's last cycle still counts as a normal halt.
                if (cpu_halted) begin
                    w_state_next = S_HALT;
                end else if (w_wd_hit) begin
                    w_state_next = S_TIMEOUT;
                end
            end
            S_HALT: begin
                select     = 1'b1;
                cpu_en     = 1'b1;
                led_halted = 1'b1;
            end
            S_TIMEOUT: begin
                select      = 1'b1;
                led_timeout = 1'b1;
            end
            default: begin
                w_state_next = S_RESET;
            end
        endcase
        if (restart) begin
            w_state_next = S_RESET;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_rst_cnt <= '0;
        end else if (r_state == S_RESET && !w_rst_done) begin
            r_rst_cnt <= r_rst_cnt + RST_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
        end else begin
            r_wd_cnt <= '0;
        end
    end

    // A restart aborts the cycle it arrives in, so no display update happens alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hex <= '0;
        end else if (!restart) begin
            case (r_state)
                S_LOAD: begin
                    if (loader_byte_valid) begin
                        r_hex <= loader_byte_val;
                    end
                end
                S_RUN: begin
                    if (cpu_halted) begin
                        r_hex <= cpu_exit_code;
                    end else if (w_wd_hit) begin
                        r_hex <= TIMEOUT_CODE;
                    end
                end
                default: begin
                    r_hex <= r_hex;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stretch_cnt <= '0;
        end else if (loader_byte_valid) begin
            r_stretch_cnt <= SW'(STRETCH_CYCLES);
        end else if (r_stretch_cnt != '0) begin
            r_stretch_cnt <= r_stretch_cnt - SW'(1);
        end
    end

    assign hex_val      = r_hex;
    assign led_activity = (r_stretch_cnt != '0);

`ifdef BOOT_CTRL_RUN_COUNT_EN
    logic [CNT_W-1:0] r_run_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cycles <= '0;
        end else if (w_run_start) begin
            r_run_cycles <= '0;
        end else if (r_state == S_RUN && !restart && r_run_cycles != '1) begin
            r_run_cycles <= r_run_cycles + CNT_W'(1);
        end
    end

    assign run_cycles = r_run_cycles;
`else
    logic w_run_start_unused;
    assign w_run_start_unused = w_run_start;
    assign run_cycles         = '0;
`endif

endmodule

// File: tb/tb_dev_boot_ctrl.sv
// Scoreboard bench for dev_boot_ctrl: a phase-level reference model queues the expected outputs
// for every driven cycle and a monitor compares them; directed scenarios add explicit value checks.
module tb_dev_boot_ctrl;

    localparam int          BW      = 8;
    localparam int          CW      = 32;
    localparam int          RSTC    = 4;
    localparam int          TOC     = 16;
    localparam int          STC     = 5;
    localparam logic [7:0]  TO_CODE = 8'hEE;
    localparam longint      RUN_MAX = (64'd1 << CW) - 1;
`ifdef BOOT_CTRL_RUN_COUNT_EN
    localparam bit RUN_EN = 1'b1;
`else
    localparam bit RUN_EN = 1'b0;
`endif

    localparam int PH_RESET   = 0;
    localparam int PH_LOAD    = 1;
    localparam int PH_RUN     = 2;
    localparam int PH_HALT    = 3;
    localparam int PH_TIMEOUT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          restart = 1'b0;
    logic          loader_done = 1'b0;
    logic [BW-1:0] loader_byte_val = '0;
    logic          loader_byte_valid = 1'b0;
    logic          cpu_halted = 1'b0;
    logic [BW-1:0] cpu_exit_code = '0;
    logic          sub_rst, select, cpu_en, led_activity, led_halted, led_timeout;
    logic [BW-1:0] hex_val;
    logic [CW-1:0] run_cycles;

    always #5 clk = ~clk;

    dev_boot_ctrl #(
        .BYTE_W         (BW),
        .RST_CYCLES     (RSTC),
        .TIMEOUT_CYCLES (TOC),
        .STRETCH_CYCLES (STC),
        .TIMEOUT_CODE   (TO_CODE),
        .CNT_W          (CW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .restart           (restart),
        .loader_done       (loader_done),
        .loader_byte_val   (loader_byte_val),
        .loader_byte_valid (loader_byte_valid),
        .cpu_halted        (cpu_halted),
        .cpu_exit_code     (cpu_exit_code),
        .sub_rst           (sub_rst),
        .select            (select),
        .cpu_en            (cpu_en),
        .hex_val           (hex_val),
        .led_activity      (led_activity),
        .led_halted        (led_halted),
        .led_timeout       (led_timeout),
        .run_cycles        (run_cycles)
    );

    typedef struct packed {
        logic          sub_rst;
        logic          select;
        logic          cpu_en;
        logic [BW-1:0] hex;
        logic          act;
        logic          halted;
        logic          tmo;
        logic [CW-1:0] run;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model state, in terms of boot phases and plain counts.
    int     ph        = PH_RESET;
    int     rst_left  = RSTC;
    int     m_hex     = 0;
    int     m_stretch = 0;
    longint m_run     = 0;
    int     m_ran     = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step(input bit r, input bit rs, input bit ld, input logic [7:0] b,
                        input bit bv, input bit hl, input logic [7:0] code);
        obs_t e;
        @(negedge clk);
        rst = r; restart = rs; loader_done = ld; loader_byte_val = b;
        loader_byte_valid = bv; cpu_halted = hl; cpu_exit_code = code;
        if (r) begin
            ph = PH_RESET; rst_left = RSTC; m_hex = 0; m_stretch = 0; m_run = 0; m_ran = 0;
        end else begin
            m_stretch = bv ? STC : ((m_stretch > 0) ? m_stretch - 1 : 0);
            if (rs) begin
                ph = PH_RESET; rst_left = RSTC;
            end else begin
                case (ph)
                    PH_RESET: begin
                        rst_left--;
                        if (rst_left == 0) ph = PH_LOAD;
                    end
                    PH_LOAD: begin
                        if (bv) m_hex = int'(b);
                        if (ld) begin ph = PH_RUN; m_run = 0; m_ran = 0; end
                    end
                    PH_RUN: begin
                        m_ran++;
                        if (m_run < RUN_MAX) m_run++;
                        if (hl) begin m_hex = int'(code); ph = PH_HALT; end
                        else if (TOC != 0 && m_ran == TOC) begin ph = PH_TIMEOUT; m_hex = int'(TO_CODE); end
                    end
                    default: ;
                endcase
            end
        end
        e.sub_rst = (ph == PH_RESET);
        e.select  = (ph == PH_RUN) || (ph == PH_HALT) || (ph == PH_TIMEOUT);
        e.cpu_en  = (ph == PH_RUN) || (ph == PH_HALT);
        e.hex     = m_hex[7:0];
        e.act     = (m_stretch != 0);
        e.halted  = (ph == PH_HALT);
        e.tmo     = (ph == PH_TIMEOUT);
        e.run     = RUN_EN ? m_run[CW-1:0] : '0;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected snapshot per clock edge of driven stimulus.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {sub_rst, select, cpu_en, hex_val, led_activity, led_halted, led_timeout, run_cycles};
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL sb cycle %0d: got %h expected %h", cyc, a, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL time limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int cnt;
        bit sel_seen;
        logic [7:0] led_vec;

        // Reset release
        step(1, 0, 0, 8'h00, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 0, 0, 8'h00);
        settle();
        cnt = sub_rst ? 1 : 0;
        for (int i = 0; i < 5; i++) begin idle(); settle(); if (sub_rst) cnt++; end
        chk("rst_pulse_len", cnt, 4);
        chk("load_select", select, 0);
        chk("load_cpu_en", cpu_en, 0);
        chk("load_hex", hex_val, 8'h00);
        $display("scenario reset_release done, checks %0d", n_checks);

        // Load then run, halt after 10 RUN cycles
        step(0, 0, 0, 8'h12, 1, 0, 8'h00);
        step(0, 0, 0, 8'h34, 1, 0, 8'h00);
        step(0, 0, 1, 8'h00, 0, 0, 8'h00);
        settle();
        chk("run_hex", hex_val, 8'h34);
        chk("run_select", select, 1);
        chk("run_cpu_en", cpu_en, 1);
        for (int i = 0; i < 9; i++) idle();
        step(0, 0, 0, 8'h00, 0, 1, 8'h2A);
        settle();
        chk("halt_hex", hex_val, 8'h2A);
        chk("halt_led", led_halted, 1);
        chk("halt_run_cycles", run_cycles, RUN_EN ? 10 : 0);
        $display("scenario load_run_halt done, checks %0d", n_checks);

        // Restart from HALT
        step(0, 1, 0, 8'h00, 0, 0, 8'h00);
        settle();
        chk("restart_led_halted", led_halted, 0);
        cnt = sub_rst ? 1 : 0;
        for (int i = 0; i < 5; i++) begin idle(); settle(); if (sub_rst) cnt++; end
        chk("restart_pulse_len", cnt, 4);
        chk("restart_select", select, 0);
        step(0, 0, 1, 8'h00, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00, 0, 1, 8'h00);
        settle();
        chk("rehalt_hex", hex_val, 8'h00);
        $display("scenario restart_from_halt done, checks %0d", n_checks);

        // Watchdog
        step(0, 1, 0, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) idle();
        step(0, 0, 1, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < 15; i++) idle();
        settle();
        chk("wd_not_yet", led_timeout, 0);
        idle();
        settle();
        chk("wd_led", led_timeout, 1);
        chk("wd_cpu_en", cpu_en, 0);
        chk("wd_hex", hex_val, 8'hEE);
        $display("scenario watchdog done, checks %0d", n_checks);

        // Halt on the watchdog's last cycle
        step(0, 1, 0, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) idle();
        step(0, 0, 1, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < 15; i++) idle();
        step(0, 0, 0, 8'h00, 0, 1, 8'h5A);
        settle();
        chk("tie_led_timeout", led_timeout, 0);
        chk("tie_led_halted", led_halted, 1);
        chk("tie_hex", hex_val, 8'h5A);
        $display("scenario halt_vs_watchdog done, checks %0d", n_checks);

        // Restart together with loader_done
        step(0, 1, 0, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) idle();
        step(0, 1, 1, 8'h00, 0, 0, 8'h00);
        settle();
        cnt = sub_rst ? 1 : 0;
        sel_seen = select;
        for (int i = 0; i < 5; i++) begin
            idle(); settle();
            if (sub_rst) cnt++;
            sel_seen |= select;
        end
        chk("restart_done_pulse_len", cnt, 4);
        chk("restart_done_no_run", sel_seen, 0);
        $display("scenario restart_vs_done done, checks %0d", n_checks);

        // LED stretch: bytes at t0 and t2
        led_vec = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || i == 2) step(0, 0, 0, 8'h77 + 8'(i), 1, 0, 8'h00);
            else idle();
            settle();
            led_vec[i] = led_activity;
        end
        chk("led_stretch", led_vec, 8'h7F);
        $display("scenario led_stretch done, checks %0d", n_checks);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 399) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 11) == 0, 8'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 19) == 0, 8'($urandom));
        end
        $display("scenario random done, checks %0d", n_checks);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
